registros_rf: RTL and testbench

Architectural integer register file for the RISC-V datapath: 32 registers of 32 bits, two asynchronous read ports (rs1/rs2) and one synchronous write port (rd). Register x0 is hard-wired to zero. The decode stage drives the read addresses and the writeback stage drives the write port. Implemented as module `registros_rf`.

---
 rtl/registros_rf.sv | 41 ++++
 tb/tb_registros_rf.sv | 136 +++++++++++++
 2 files changed

// File: rtl/registros_rf.sv
// Integer register file: 32 x DATA_W with two combinational read ports and one synchronous write port.
// Optional write-first forwarding to the read ports when REGISTROS_BYPASS_EN is defined.
module registros_rf #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegW,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] write,
  output logic [DATA_W-1:0] R1,
  output logic [DATA_W-1:0] R2
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  // Reset has priority over a write on the same edge; x0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (RegW && (A3 != '0)) begin
      regs[A3] <= write;
    end
  end

  always_comb begin
    R1 = (A1 == '0) ? '0 : regs[A1];
    R2 = (A2 == '0) ? '0 : regs[A2];
`ifdef REGISTROS_BYPASS_EN
    // A3 != 0 together with the address match already keeps x0 reading zero.
    if (!rst && RegW && (A3 != '0) && (A1 == A3)) R1 = write;
    if (!rst && RegW && (A3 != '0) && (A2 == A3)) R2 = write;
`endif
  end

endmodule

// File: tb/tb_registros_rf.sv
// Scoreboard bench for registros_rf: stimulus queues expected R1/R2, a negedge monitor pops and compares.
module tb_registros_rf;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegW;
  logic [4:0]  A1, A2, A3;
  logic [31:0] write;
  logic [31:0] R1, R2;

  typedef struct {
    string       name;
    logic [31:0] r1;
    logic [31:0] r2;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef REGISTROS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  registros_rf #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .RegW(RegW),
    .A1(A1), .A2(A2), .A3(A3),
    .write(write), .R1(R1), .R2(R2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (R1 !== e.r1) begin
        errors++;
        $display("FAIL %s R1 got %h expected %h", e.name, R1, e.r1);
      end
      checks++;
      if (R2 !== e.r2) begin
        errors++;
        $display("FAIL %s R2 got %h expected %h", e.name, R2, e.r2);
      end
    end
  end

  // Inputs change just after a rising edge and are sampled at the next one.
  task automatic drive(input logic r, input logic we, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] a3, input logic [31:0] wd);
    @(posedge clk);
    #1;
    rst = r; RegW = we; A1 = a1; A2 = a2; A3 = a3; write = wd;
  endtask

  task automatic expect_rd(input string name, input logic [31:0] e1, input logic [31:0] e2);
    exp_t e;
    e.name = name; e.r1 = e1; e.r2 = e2;
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; RegW = 1'b0; A1 = '0; A2 = '0; A3 = '0; write = '0;

    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 5'(i), 5'(31 - i), 0, 0);
      expect_rd("reset_sweep", 32'h0, 32'h0);
    end

    drive(0, 1, 0, 0, 1, 32'd50);
    drive(0, 0, 1, 1, 0, 0);
    expect_rd("wr_x1", 32'd50, 32'd50);

    drive(0, 1, 1, 0, 5, 32'd80);
    drive(0, 1, 1, 5, 5, 32'd80);
    expect_rd("wr_x5_mid", 32'd50, 32'd80);
    drive(0, 0, 1, 5, 0, 0);
    expect_rd("wr_x5", 32'd50, 32'd80);

    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 2, 2, 32'hDEADBEEF);
      expect_rd("regw_off", 32'd50, 32'h0);
    end
    drive(0, 0, 1, 2, 0, 0);
    expect_rd("regw_off_after", 32'd50, 32'h0);

    drive(0, 1, 0, 0, 0, 32'hFFFFFFFF);
    expect_rd("x0_pre", 32'h0, 32'h0);
    drive(0, 0, 0, 0, 0, 0);
    expect_rd("x0_post", 32'h0, 32'h0);

    drive(1, 1, 1, 5, 1, 32'd7);
    expect_rd("rst_pre_nofwd", 32'd50, 32'd80);
    drive(0, 1, 1, 5, 1, 32'd7);
    expect_rd("rst_cleared", BYP ? 32'd7 : 32'h0, 32'h0);
    drive(0, 0, 1, 5, 0, 0);
    expect_rd("rst_resume_wr", 32'd7, 32'h0);

    drive(0, 1, 0, 0, 3, 32'h55);
    drive(0, 1, 3, 3, 3, 32'h1234);
    expect_rd("bypass_pre", BYP ? 32'h1234 : 32'h55, BYP ? 32'h1234 : 32'h55);
    drive(0, 0, 3, 7, 0, 0);
    expect_rd("bypass_post", 32'h1234, 32'h0);

    drive(0, 1, 3, 4, 4, 32'hA5A5);
    expect_rd("fwd_other_addr", 32'h1234, BYP ? 32'hA5A5 : 32'h0);
    drive(0, 0, 4, 0, 0, 0);
    expect_rd("wr_x4", 32'hA5A5, 32'h0);

    drive(0, 1, 0, 0, 31, 32'hCAFEF00D);
    drive(0, 0, 31, 30, 0, 0);
    expect_rd("wr_x31", 32'hCAFEF00D, 32'h0);
    drive(0, 0, 1, 31, 0, 0);
    expect_rd("retain", 32'd7, 32'hCAFEF00D);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
